// File: rtl/logic_accumulator.sv
// Folds a burst of gate results into one accumulator word using a per-beat
// operation, then presents the result and beat count over a valid/ready handshake.
module logic_accumulator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_op,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] acc,
                                               input logic [DATA_W-1:0] d,
                                               input logic [2:0]        op);
        logic [DATA_W-1:0] r;
        r = acc;
        case (op)
            3'b000: r = d;
            3'b001: r = acc & d;
            3'b010: r = acc | d;
            3'b011: r = acc ^ d;
            3'b100: r = ~(acc ^ d);
            3'b101: r = acc + d;
            3'b110: r = acc;
            3'b111: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // First beat of a burst always loads, whatever in_op says.
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = fold(acc_q, in_data, in_op);
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        accept    = in_valid & in_ready;
        out_data  = out_valid ? acc_q : '0;
        out_count = out_valid ? cnt_q : '0;
    end

endmodule

// File: tb/tb_logic_accumulator.sv
// Directed self-checking bench for logic_accumulator: one task per scenario,
// expected values computed by hand.
module tb_logic_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_op;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_count;
    logic        busy;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    logic_accumulator #(.DATA_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic beat(input logic [31:0] d, input logic [2:0] op, input logic last);
        int n;
        in_valid = 1'b1; in_data = d; in_op = op; in_last = last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            $display("FAIL beat_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, out_data, out_count} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0})
            $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b data=%h cnt=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, busy, out_data, out_count);
        else passed++;
    endtask

    task automatic test_single_beat();
        beat(32'h0000FFFF, 3'b011, 1'b1);
        total++;
        if ({out_valid, busy, in_ready, out_data, out_count} !== {1'b1, 1'b1, 1'b0, 32'h0000FFFF, 8'd1})
            $display("FAIL single_beat: vld=%0b busy=%0b rdy=%0b data=%h cnt=%0d, required 1 1 0 0000ffff 1",
                     out_valid, busy, in_ready, out_data, out_count);
        else passed++;
        drain();
        total++;
        if ({out_valid, busy, in_ready, out_data, out_count} !== {1'b0, 1'b0, 1'b1, 32'h0, 8'd0})
            $display("FAIL single_drain: vld=%0b busy=%0b rdy=%0b data=%h cnt=%0d, required 0 0 1 0 0",
                     out_valid, busy, in_ready, out_data, out_count);
        else passed++;
    endtask

    task automatic test_xnor_fold();
        beat(32'h0000F0F0, 3'b010, 1'b0);
        total++;
        if ({busy, out_valid, out_data} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL xnor_accum_state: busy=%0b vld=%0b data=%h, required 1 0 0", busy, out_valid, out_data);
        else passed++;
        beat(32'h0000FF00, 3'b100, 1'b1);
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'hFFFFF00F, 8'd2})
            $display("FAIL xnor_fold: vld=%0b data=%h cnt=%0d, required 1 fffff00f 2", out_valid, out_data, out_count);
        else passed++;
        drain();
    endtask

    task automatic test_add_wrap();
        beat(32'hFFFFFFFF, 3'b000, 1'b0);
        beat(32'h00000002, 3'b101, 1'b1);
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'h00000001, 8'd2})
            $display("FAIL add_wrap: vld=%0b data=%h cnt=%0d, required 1 00000001 2", out_valid, out_data, out_count);
        else passed++;
        drain();
    endtask

    task automatic test_all_ops();
        beat(32'h0F0F0F0F, 3'b111, 1'b0);   // forced LOAD in IDLE
        beat(32'h00FF00FF, 3'b001, 1'b0);   // 000F000F
        tick(); tick();                     // idle gap in ACCUM
        total++;
        if ({busy, in_ready, out_valid} !== {1'b1, 1'b1, 1'b0})
            $display("FAIL accum_gap: busy=%0b rdy=%0b vld=%0b, required 1 1 0", busy, in_ready, out_valid);
        else passed++;
        beat(32'hF0000000, 3'b010, 1'b0);   // F00F000F
        beat(32'h0000FFFF, 3'b011, 1'b0);   // F00FFFF0
        beat(32'h12345678, 3'b110, 1'b0);   // F00FFFF0
        beat(32'h87654321, 3'b111, 1'b0);   // 00000000
        beat(32'h0000ABCD, 3'b000, 1'b0);   // 0000ABCD
        beat(32'h00000003, 3'b101, 1'b1);   // 0000ABD0
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'h0000ABD0, 8'd8})
            $display("FAIL all_ops: vld=%0b data=%h cnt=%0d, required 1 0000abd0 8", out_valid, out_data, out_count);
        else passed++;
        drain();
    endtask

    task automatic test_backpressure();
        beat(32'h00001111, 3'b000, 1'b1);
        in_valid = 1'b1; in_data = 32'h00002222; in_op = 3'b000; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({in_ready, out_valid, out_data, out_count} !== {1'b0, 1'b1, 32'h00001111, 8'd1})
                $display("FAIL bp_hold[%0d]: rdy=%0b vld=%0b data=%h cnt=%0d, required 0 1 00001111 1",
                         i, in_ready, out_valid, out_data, out_count);
            else passed++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid, busy} !== {1'b1, 1'b0, 1'b0})
            $display("FAIL bp_release: rdy=%0b vld=%0b busy=%0b, required 1 0 0", in_ready, out_valid, busy);
        else passed++;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'h00002222, 8'd1})
            $display("FAIL bp_held_beat: vld=%0b data=%h cnt=%0d, required 1 00002222 1", out_valid, out_data, out_count);
        else passed++;
        drain();
    endtask

    task automatic test_saturation();
        in_valid = 1'b1; in_data = 32'h00005A5A; in_op = 3'b110; in_last = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        total++;
        if ({busy, out_valid} !== {1'b1, 1'b0})
            $display("FAIL sat_accum: busy=%0b vld=%0b, required 1 0", busy, out_valid);
        else passed++;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'h00005A5A, 8'd255})
            $display("FAIL saturation: vld=%0b data=%h cnt=%0d, required 1 00005a5a 255", out_valid, out_data, out_count);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid();
        beat(32'h00000001, 3'b010, 1'b0);
        beat(32'h00000002, 3'b010, 1'b0);
        beat(32'h00000004, 3'b010, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, out_data, out_count} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0})
            $display("FAIL reset_mid: rdy=%0b vld=%0b busy=%0b data=%h cnt=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, busy, out_data, out_count);
        else passed++;
        beat(32'h00001234, 3'b010, 1'b1);
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 32'h00001234, 8'd1})
            $display("FAIL reset_mid_next: vld=%0b data=%h cnt=%0d, required 1 00001234 1", out_valid, out_data, out_count);
        else passed++;
        rst = 1'b1;                         // reset while result pending
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, out_data, out_count} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0})
            $display("FAIL reset_hold: rdy=%0b vld=%0b busy=%0b data=%h cnt=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, busy, out_data, out_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_xnor_fold();
        test_add_wrap();
        test_all_ops();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
